// File: rtl/svm_pkg.sv
// Shared types and default widths for the SVM sample loader.
package svm_pkg;

    localparam int unsigned DefNFeatures     = 33;
    localparam int unsigned DefInputWidth    = 4;
    localparam int unsigned DefClassWidth    = 3;
    localparam int unsigned DefTimeoutCycles = 1024;

    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StWait,
        StResult
    } state_e;

endpackage

// File: rtl/svm_sample_loader_if.sv
// Feature stream, core handshake and result handshake of the sample loader.
// slave: the loader itself; master: whatever surrounds it (feeder, core, consumer).
interface svm_sample_loader_if #(
    parameter int unsigned N_FEATURES  = svm_pkg::DefNFeatures,
    parameter int unsigned INPUT_WIDTH = svm_pkg::DefInputWidth,
    parameter int unsigned CLASS_WIDTH = svm_pkg::DefClassWidth
);
    logic [INPUT_WIDTH-1:0]            feat_in;
    logic                              feat_valid;
    logic                              feat_ready;
    logic [N_FEATURES*INPUT_WIDTH-1:0] core_in;
    logic                              core_start;
    logic                              core_ready;
    logic [CLASS_WIDTH-1:0]            core_class;
    logic [CLASS_WIDTH-1:0]            res_class;
    logic                              res_valid;
    logic                              res_ready;
    logic                              res_timeout;

    modport slave (
        input  feat_in, feat_valid, core_ready, core_class, res_ready,
        output feat_ready, core_in, core_start, res_class, res_valid, res_timeout
    );

    modport master (
        output feat_in, feat_valid, core_ready, core_class, res_ready,
        input  feat_ready, core_in, core_start, res_class, res_valid, res_timeout
    );
endinterface

// File: rtl/svm_sample_loader.sv
// Collects N_FEATURES serial words MSB-first, starts the SVM core, latches its class.
// Define SVM_TIMEOUT_EN to add a WAIT watchdog that forces an all-ones timeout result.
module svm_sample_loader
    import svm_pkg::*;
#(
    parameter int unsigned N_FEATURES     = DefNFeatures,
    parameter int unsigned INPUT_WIDTH    = DefInputWidth,
    parameter int unsigned CLASS_WIDTH    = DefClassWidth,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input logic                clk,
    input logic                rst,
    svm_sample_loader_if.slave bus
);
    localparam int unsigned SampleW = N_FEATURES * INPUT_WIDTH;
    localparam int unsigned CntW    = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N_FEATURES - 1);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SampleW-1:0]     core_in_q, core_in_d;
    logic [CLASS_WIDTH-1:0] res_class_q, res_class_d;
    logic                   core_ready_q;
    logic                   ready_rise;
    logic                   feat_ready;
    logic                   core_start;
    logic                   res_valid;

`ifdef SVM_TIMEOUT_EN
    localparam int unsigned WdogW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             res_timeout_q, res_timeout_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // A core_ready already high when WAIT is entered is not a rise, so a stale level is ignored.
    assign ready_rise = bus.core_ready && !core_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_in_d   = core_in_q;
        res_class_d = res_class_q;
        feat_ready  = 1'b0;
        core_start  = 1'b0;
        res_valid   = 1'b0;
`ifdef SVM_TIMEOUT_EN
        wdog_d        = '0;
        res_timeout_d = res_timeout_q;
`endif
        case (state_q)
            StLoad: begin
                feat_ready = 1'b1;
                if (bus.feat_valid) begin
                    core_in_d = (core_in_q << INPUT_WIDTH) | SampleW'(bus.feat_in);
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StStart;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StStart: begin
                core_start = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                if (ready_rise) begin
                    res_class_d = bus.core_class;
                    state_d     = StResult;
                end
`ifdef SVM_TIMEOUT_EN
                else if (wdog_q == WdogLast) begin
                    res_class_d   = '1;
                    res_timeout_d = 1'b1;
                    state_d       = StResult;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
`endif
            end
            StResult: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
`ifdef SVM_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StLoad;
            cnt_q        <= '0;
            core_in_q    <= '0;
            res_class_q  <= '0;
            core_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_in_q    <= core_in_d;
            res_class_q  <= res_class_d;
            core_ready_q <= bus.core_ready;
        end
    end

`ifdef SVM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q        <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.res_timeout = res_timeout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    assign bus.feat_ready = feat_ready;
    assign bus.core_start = core_start;
    assign bus.core_in    = core_in_q;
    assign bus.res_class  = res_class_q;
    assign bus.res_valid  = res_valid;

endmodule

// File: doc/svm_sample_loader.md
SVM_SAMPLE_LOADER -- requirements
Module: svm_sample_loader

Interface
REQ-001 SHALL have parameter N_FEATURES, default 33, the number of features per sample.
REQ-002 SHALL have parameter INPUT_WIDTH, default 4, the bits per feature.
REQ-003 SHALL have parameter CLASS_WIDTH, default 3, the bits of the class index.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit (used only with SVM_TIMEOUT_EN).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 SHALL have rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have feat_in  input  INPUT_WIDTH  serial feature word.
REQ-008 SHALL have feat_valid  input  1  feature word present.
REQ-009 SHALL have feat_ready  output  1  loader accepts a feature word.
REQ-010 SHALL have core_in  output  N_FEATURES*INPUT_WIDTH  assembled sample to the sequential SVM core.
REQ-011 SHALL have core_start  output  1  one-cycle start pulse to the core.
REQ-012 SHALL have core_ready  input  1  core completion level.
REQ-013 SHALL have core_class  input  CLASS_WIDTH  winning class from the core.
REQ-014 SHALL have res_class  output  CLASS_WIDTH  latched result.
REQ-015 SHALL have res_valid  output  1  result available.
REQ-016 SHALL have res_ready  input  1  consumer takes the result.
REQ-017 SHALL have res_timeout  output  1  result produced by the watchdog (tied 0 without SVM_TIMEOUT_EN).

Function
REQ-018 SHALL implement the FSM LOAD -> START -> WAIT -> RESULT -> LOAD.
REQ-019 SHALL, in LOAD, assert feat_ready and accept a word on each cycle where feat_valid&&feat_ready.
REQ-020 SHALL pack the first accepted word at core_in[N_FEATURES*INPUT_WIDTH-1 -: INPUT_WIDTH] (MSB-first) and word k at the k-th slice down from the top.
REQ-021 SHALL use a feature counter 0..N_FEATURES-1; on acceptance of word N_FEATURES-1, clear it and go to START.
REQ-022 SHALL hold feat_ready low in START, WAIT and RESULT, and accept no words there.
REQ-023 SHALL assert core_start for exactly one cycle, in START, then go to WAIT.
REQ-024 SHALL hold core_in stable from START until re-entry to LOAD.
REQ-025 SHALL, in WAIT, detect a rising edge of core_ready (registered previous value), latch core_class into res_class, and go to RESULT; a core_ready high already in the START cycle SHALL be ignored.
REQ-026 SHALL assert res_valid only in RESULT, holding res_class stable until res_valid&&res_ready, then go to LOAD.
REQ-027 SHALL give a total latency from last-word acceptance to core_start of 1 cycle, and from the core_ready rise to res_valid of 1 cycle.
REQ-028 SHALL allow res_ready high on res_valid's first cycle (one-cycle RESULT), with feat_ready high on the next cycle.

Reset
REQ-029 SHALL force, on rst, state LOAD, counter 0, core_in 0, core_start 0, res_class 0, res_valid 0, res_timeout 0, core_ready edge register 0, and watchdog 0.
REQ-030 SHALL, on rst asserted mid-sample or in WAIT, discard the partial sample or pending result; after release the first accepted word is feature 0.

Configuration
REQ-031 SHALL, with SVM_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYCLES without a core_ready rise, go to RESULT with res_class all-ones and res_timeout 1 (cleared on leaving RESULT).
REQ-032 SHALL, without SVM_TIMEOUT_EN, omit the watchdog and wait in WAIT indefinitely.

Structure
REQ-033 SHALL place the state enum type and the default widths in shared package svm_pkg.
REQ-034 SHALL be a single module with no sub-modules; the packing shift register is inline.

Verification
REQ-035 Bench SHALL stream 33 words 0x1..0xF repeating with feat_valid constantly high; the core answers core_ready after 18 cycles with class 5 -> core_in[131:128]=0x1, exactly one core_start, res_class=5.
REQ-036 Bench SHALL insert random feat_valid gaps -> core_in is identical to the gap-free case and core_start occurs only after the 33rd word.
REQ-037 Bench SHALL hold res_ready low for 10 cycles -> res_valid and res_class stable and feat_ready 0 throughout.
REQ-038 Bench SHALL assert rst after 20 words, then send 33 words -> first post-reset word lands at the top slice and exactly one core_start occurs.
REQ-039 Bench SHALL, with SVM_TIMEOUT_EN and TIMEOUT_CYCLES=16, never raise core_ready -> after 16 WAIT cycles res_valid=1, res_class=3'b111, res_timeout=1.
